// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory data-port arbiter: FSM encoding,
// memory map constants and requester ids.
package mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  localparam logic [31:0] MEM_SIZE   = 32'h4000;
  localparam logic [31:0] INST_BASE  = 32'h3000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority flop flips to the loser side
// whenever a grant is accepted.
module rr_arb2
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_o
);

  logic prio_q, prio_d;

  always_comb begin
    if (req_i == 2'b11) gnt_o = prio_q;
    else                gnt_o = req_i[1] ? REQ_LDR : REQ_CPU;
    prio_d = accept_i ? ~gnt_o : prio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= REQ_CPU;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory data port between the CPU and the loader, and
// sequences each access into a clean read or a single held-stable write strobe.
module mem_port_arbiter #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] MEM_SIZE  = mem_pkg::MEM_SIZE,
  parameter logic [31:0] INST_BASE = mem_pkg::INST_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_SIZE - WORD_BYTES);
  localparam logic [ADDR_W-1:0] INST_LO   = ADDR_W'(INST_BASE);

  state_e            state_q;
  logic              we_q, id_q;
  logic              done0_q, done1_q, err_q, mem_read_q, mem_write_q;
  logic [DATA_W-1:0] rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              gnt_id, grant;
  logic              sel_we, chk_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign grant = (state_q == S_IDLE) && (req0 || req1);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({req1, req0}),
    .accept_i (grant),
    .gnt_o    (gnt_id)
  );

  // The check sees exactly the values being latched, so a rejected access can
  // complete in the very next cycle without ever touching the memory port.
  always_comb begin
    sel_we    = (gnt_id == REQ_LDR) ? we1    : we0;
    sel_addr  = (gnt_id == REQ_LDR) ? addr1  : addr0;
    sel_wdata = (gnt_id == REQ_LDR) ? wdata1 : wdata0;
    chk_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD) ||
                (sel_we && (gnt_id == REQ_CPU) && (sel_addr >= INST_LO));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      id_q        <= REQ_CPU;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            we_q <= sel_we;
            id_q <= gnt_id;
            if (chk_err) begin
              state_q <= S_RESP;
              done0_q <= (gnt_id == REQ_CPU);
              done1_q <= (gnt_id == REQ_LDR);
              err_q   <= 1'b1;
            end else begin
              state_q     <= S_SETUP;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
              mem_read_q  <= ~sel_we;
            end
          end
        end
        S_SETUP: begin
          if (we_q) begin
            state_q     <= S_STROBE;
            mem_write_q <= 1'b1;
          end else begin
            state_q <= S_RESP;
            rdata_q <= mem_rdata;
            done0_q <= (id_q == REQ_CPU);
            done1_q <= (id_q == REQ_LDR);
            err_q   <= 1'b0;
          end
        end
        S_STROBE: state_q <= S_HOLD;
        // Address and data stay put one extra cycle after the strobe drops.
        S_HOLD: begin
          state_q <= S_RESP;
          done0_q <= (id_q == REQ_CPU);
          done1_q <= (id_q == REQ_LDR);
          err_q   <= 1'b0;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// accesses compared against a rule-based reference model and shadow memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, err;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] tb_mem  [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        bd_we;
  logic [11:0] bd_idx;
  logic [31:0] bd_dat;

  int checks = 0;
  int errors = 0;
  bit model_prio;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .done0     (done0),
    .done1     (done1),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Memory array: asynchronous read, write on the clock edge while mem_write is high.
  assign mem_rdata = tb_mem[mem_addr[13:2]];
  always @(posedge clk) begin
    if (mem_write)  tb_mem[mem_addr[13:2]] <= mem_wdata;
    else if (bd_we) tb_mem[bd_idx] <= bd_dat;
  end

  function automatic bit model_err(input bit id, input bit we, input logic [31:0] a);
    return (a % 4 != 0) || (a > 32'd16380) || (we && id == 1'b0 && a >= 32'd12288);
  endfunction

  function automatic int model_lat(input bit e, input bit we);
    return e ? 1 : (we ? 4 : 2);
  endfunction

  task automatic do_access(input bit id, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic d0,
                           output logic d1, output logic e, output logic [31:0] rd,
                           output int rc, output int wc, output int both,
                           output bit unstable);
    @(negedge clk);
    if (id) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else    begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    lat = -1; rc = 0; wc = 0; both = 0; unstable = 1'b0;
    d0 = 1'b0; d1 = 1'b0; e = 1'b0; rd = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_read) rc++;
      if (mem_write) wc++;
      if (mem_read && mem_write) both++;
      if (done0 || done1) begin
        lat = c; d0 = done0; d1 = done1; e = err; rd = rdata;
      end else if (mem_addr !== addr || mem_wdata !== wd) begin
        unstable = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (done0 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b%b required 00", done1, done0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b required 0", mem_read, mem_write); end
    checks++; if (rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h required 0", rdata, mem_addr, mem_wdata); end
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      bd_we  = 1'b1;
      bd_idx = i[11:0];
      bd_dat = (i == 4) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = bd_dat;
    end
    @(negedge clk);
    bd_we = 1'b0;
    rst_n = 1'b1;
    model_prio = 1'b0;
  endtask

  task automatic test_cpu_read;
    int lat, rc, wc, both; logic d0, d1, e; logic [31:0] rd; bit us;
    do_access(1'b0, 1'b0, 32'h10, 32'h0, lat, d0, d1, e, rd, rc, wc, both, us);
    checks++; if (lat != 2) begin errors++; $display("FAIL read_latency: got %0d required 2", lat); end
    checks++; if (d0 !== 1'b1 || d1 !== 1'b0) begin errors++; $display("FAIL read_done_id: got done1/0=%b%b required 01", d1, d0); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_err: got %b required 0", e); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h required deadbeef", rd); end
    checks++; if (rc != 1 || wc != 0) begin errors++; $display("FAIL read_strobes: got rd=%0d wr=%0d required 1/0", rc, wc); end
    model_prio = 1'b1;
  endtask

  task automatic test_cpu_write;
    int lat, rc, wc, both; logic d0, d1, e; logic [31:0] rd; bit us;
    do_access(1'b0, 1'b1, 32'h20, 32'h12345678, lat, d0, d1, e, rd, rc, wc, both, us);
    checks++; if (lat != 4) begin errors++; $display("FAIL write_latency: got %0d required 4", lat); end
    checks++; if (d0 !== 1'b1 || d1 !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL write_done: got done1/0=%b%b err=%b required 01 err 0", d1, d0, e); end
    checks++; if (wc != 1 || rc != 0) begin errors++; $display("FAIL write_strobes: got wr=%0d rd=%0d required 1/0", wc, rc); end
    checks++; if (us) begin errors++; $display("FAIL write_stable: got unstable=%b required 0", us); end
    ref_mem[8] = 32'h12345678;
    do_access(1'b0, 1'b0, 32'h20, 32'h0, lat, d0, d1, e, rd, rc, wc, both, us);
    checks++; if (rd !== 32'h12345678 || lat != 2) begin errors++; $display("FAIL write_readback: got %h lat %0d required 12345678 lat 2", rd, lat); end
    model_prio = 1'b1;
  endtask

  task automatic test_reject;
    logic [31:0] addrs [3];
    bit          wes   [3];
    int lat, rc, wc, both; logic d0, d1, e; logic [31:0] rd; bit us;
    addrs[0] = 32'h3000; wes[0] = 1'b1;
    addrs[1] = 32'h0006; wes[1] = 1'b0;
    addrs[2] = 32'h3FFD; wes[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_access(1'b0, wes[k], addrs[k], 32'hFFFF0000, lat, d0, d1, e, rd, rc, wc, both, us);
      checks++; if (lat != 1 || d0 !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL reject_%0d: got lat=%0d done0=%b err=%b required 1/1/1", k, lat, d0, e); end
      checks++; if (rc != 0 || wc != 0) begin errors++; $display("FAIL reject_quiet_%0d: got rd=%0d wr=%0d required 0/0", k, rc, wc); end
    end
    model_prio = 1'b1;
  endtask

  task automatic test_loader_write;
    int lat, rc, wc, both; logic d0, d1, e; logic [31:0] rd; bit us;
    do_access(1'b1, 1'b1, 32'h3000, 32'hA5A55A5A, lat, d0, d1, e, rd, rc, wc, both, us);
    checks++; if (lat != 4 || d1 !== 1'b1 || d0 !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL loader_write: got lat=%0d done1/0=%b%b err=%b required 4 10 0", lat, d1, d0, e); end
    checks++; if (wc != 1 || us) begin errors++; $display("FAIL loader_strobe: got wr=%0d unstable=%b required 1/0", wc, us); end
    ref_mem[12'hC00] = 32'hA5A55A5A;
    do_access(1'b0, 1'b0, 32'h3000, 32'h0, lat, d0, d1, e, rd, rc, wc, both, us);
    checks++; if (rd !== 32'hA5A55A5A || e !== 1'b0) begin errors++; $display("FAIL loader_readback: got %h err %b required a5a55a5a err 0", rd, e); end
    model_prio = 1'b1;
  endtask

  task automatic test_contention;
    bit exp_id; int n, last, cyc;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4; wdata1 = 32'h0;
    exp_id = model_prio; n = 0; last = 0; cyc = 0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (done0 || done1) begin
        checks++; if (done1 !== exp_id || done0 !== ~exp_id) begin errors++; $display("FAIL contention_order_%0d: got done1/0=%b%b required grant %0d", n, done1, done0, exp_id); end
        checks++; if (rdata !== ref_mem[exp_id ? 1 : 0]) begin errors++; $display("FAIL contention_data_%0d: got %h required %h", n, rdata, ref_mem[exp_id ? 1 : 0]); end
        checks++; if (cyc - last != ((n == 0) ? 2 : 3)) begin errors++; $display("FAIL contention_interval_%0d: got %0d required %0d", n, cyc - last, (n == 0) ? 2 : 3); end
        last = cyc; n++; exp_id = ~exp_id;
        if (n == 6) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (n != 6) begin errors++; $display("FAIL contention_timeout: got %0d completions required 6", n); end
    model_prio = exp_id;
  endtask

  task automatic test_random;
    bit id, we, exp_e; int kind, exp_lat;
    logic [31:0] a, wd, exp_rd;
    int lat, rc, wc, both; logic d0, d1, e; logic [31:0] rd; bit us;
    for (int i = 0; i < 40; i++) begin
      id = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      case (kind)
        3:       a = 32'h3000 + 32'(4 * $urandom_range(0, 1023));
        4:       a = 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
        5:       a = 32'h3FFC + 32'($urandom_range(1, 300));
        default: a = 32'(4 * $urandom_range(0, 63));
      endcase
      wd = $urandom;
      exp_e = model_err(id, we, a);
      exp_lat = model_lat(exp_e, we);
      exp_rd = ref_mem[a[13:2]];
      do_access(id, we, a, wd, lat, d0, d1, e, rd, rc, wc, both, us);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand_latency_%0d: got %0d required %0d (addr %h we %b id %b)", i, lat, exp_lat, a, we, id); end
      checks++; if (d0 !== ~id || d1 !== id) begin errors++; $display("FAIL rand_done_id_%0d: got done1/0=%b%b required id %b", i, d1, d0, id); end
      checks++; if (e !== exp_e) begin errors++; $display("FAIL rand_err_%0d: got %b required %b (addr %h)", i, e, exp_e, a); end
      checks++; if (rc != ((!exp_e && !we) ? 1 : 0) || wc != ((!exp_e && we) ? 1 : 0) || both != 0) begin errors++; $display("FAIL rand_strobes_%0d: got rd=%0d wr=%0d both=%0d", i, rc, wc, both); end
      if (!exp_e && !we) begin
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata_%0d: got %h required %h", i, rd, exp_rd); end
      end
      if (!exp_e && we) begin
        checks++; if (us) begin errors++; $display("FAIL rand_stable_%0d: got unstable=%b required 0", i, us); end
        ref_mem[a[13:2]] = wd;
      end
      model_prio = ~id;
    end
  endtask

  task automatic test_reset_mid_write;
    bit hit, seen; int cyc;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hCAFEF00D;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      if (mem_write) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_strobe_seen: got 0 required 1"); end
    #2; rst_n = 1'b0; req0 = 1'b0; we0 = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL rst_async_clear: got wr=%b rd=%b required 0/0", mem_write, mem_read); end
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done0 || done1) seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done0 || done1) seen = 1'b1;
    checks++; if (seen) begin errors++; $display("FAIL rst_no_done: got done pulse required none"); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    hit = 1'b0; cyc = 0;
    while (!hit && cyc < 10) begin
      @(negedge clk); cyc++;
      if (done0 || done1) begin
        hit = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (done0 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL rst_prio: got done1/0=%b%b required 01", done1, done0); end
        checks++; if (cyc != 2 || rdata !== ref_mem[0]) begin errors++; $display("FAIL rst_first_read: got lat %0d data %h required 2 %h", cyc, rdata, ref_mem[0]); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (!hit) begin errors++; $display("FAIL rst_first_timeout: got no done required done0"); end
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    bd_we = 1'b0; bd_idx = '0; bd_dat = '0;
    test_reset;
    test_cpu_read;
    test_cpu_write;
    test_reject;
    test_loader_write;
    test_contention;
    test_random;
    test_reset_mid_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
